// File: rtl/weight_bram_pkg.sv
// Shared parameters and sweep state encoding for the weight BRAM reader.
package weight_bram_pkg;

    localparam int DEF_DEPTH    = 28;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_DATA_W   = 16;
    localparam int FIFO_ENTRIES = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } sweep_state_t;

endpackage

// File: rtl/weight_skid_fifo.sv
// Two-entry FIFO holding {index, data} pairs between the BRAM read port and the MAC.
module weight_skid_fifo
    import weight_bram_pkg::*;
#(
    parameter int WIDTH = 21
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] slots [FIFO_ENTRIES];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == 2'(FIFO_ENTRIES));
    assign empty     = (count == 2'd0);
    assign do_push   = push && (!full || pop);
    assign do_pop    = pop && !empty;
    assign head_data = empty ? '0 : slots[rd_ptr];

    // Pointer and occupancy bookkeeping; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; no reset needed because the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            slots[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/weight_stream_reader.sv
// Sweeps a neuron's weight BRAM once per START and streams every word to the MAC.
module weight_stream_reader
    import weight_bram_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    output logic              BRAM_EN,
    output logic              BRAM_WE,
    output logic [ADDR_W-1:0] BRAM_ADDR,
    output logic [DATA_W-1:0] BRAM_DI,
    input  logic [DATA_W-1:0] BRAM_DO,
    output logic [DATA_W-1:0] W_DATA,
    output logic [ADDR_W-1:0] W_INDEX,
    output logic              W_VALID,
    output logic              W_LAST,
    input  logic              W_READY,
    output logic              BUSY,
    output logic              DONE
);

    localparam int                ENTRY_W  = ADDR_W + DATA_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    sweep_state_t       state_q;
    sweep_state_t       state_d;
    logic               en_d;
    logic [ADDR_W-1:0]  addr_d;
    logic               busy_d;
    logic               done_d;

    logic               pop;
    logic               push;
    logic               can_issue;
    logic [2:0]         occ_next;
    logic               fifo_full;
    logic               fifo_empty;
    logic [1:0]         fifo_count;
    logic [ENTRY_W-1:0] head_entry;

    // The BRAM is read-only from this side.
    assign BRAM_WE = 1'b0;
    assign BRAM_DI = '0;

    // A read issued last edge lands in the buffer this edge, so BRAM_EN doubles as "read in flight".
    assign pop       = W_VALID & W_READY;
    assign push      = BRAM_EN;
    assign occ_next  = {1'b0, fifo_count} + {2'b00, push} - {2'b00, pop};
    assign can_issue = (occ_next < 3'd2) && !(fifo_full && !pop);

    assign W_VALID = !fifo_empty;
    assign W_INDEX = head_entry[ENTRY_W-1:DATA_W];
    assign W_DATA  = head_entry[DATA_W-1:0];
    assign W_LAST  = W_VALID && (W_INDEX == LAST_IDX);

    weight_skid_fifo #(
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (RST_N),
        .push      (push),
        .push_data ({BRAM_ADDR, BRAM_DO}),
        .pop       (pop),
        .head_data (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Sweep state and registered BRAM request / status outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            BRAM_EN   <= 1'b0;
            BRAM_ADDR <= '0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            state_q   <= state_d;
            BRAM_EN   <= en_d;
            BRAM_ADDR <= addr_d;
            BUSY      <= busy_d;
            DONE      <= done_d;
        end
    end

    // Next-state logic: issue reads while credit allows, then wait for the last beat to leave.
    always_comb begin
        state_d = state_q;
        en_d    = 1'b0;
        addr_d  = BRAM_ADDR;
        busy_d  = BUSY;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (START) begin
                    en_d    = 1'b1;
                    addr_d  = '0;
                    busy_d  = 1'b1;
                    state_d = (LAST_IDX == '0) ? DRAIN : FETCH;
                end
            end
            FETCH: begin
                if (can_issue) begin
                    en_d   = 1'b1;
                    addr_d = BRAM_ADDR + ADDR_W'(1);
                    if (addr_d == LAST_IDX) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && W_LAST) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_weight_stream_reader.sv
// Randomised self-checking bench for weight_stream_reader against a BRAM model and an in-order scoreboard.
module tb_weight_stream_reader;

    localparam int DEPTH  = 28;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 16;

    logic              CLK = 1'b0;
    logic              RST_N;
    logic              START;
    logic              BRAM_EN;
    logic              BRAM_WE;
    logic [ADDR_W-1:0] BRAM_ADDR;
    logic [DATA_W-1:0] BRAM_DI;
    logic [DATA_W-1:0] BRAM_DO = '0;
    logic [DATA_W-1:0] W_DATA;
    logic [ADDR_W-1:0] W_INDEX;
    logic              W_VALID;
    logic              W_LAST;
    logic              W_READY;
    logic              BUSY;
    logic              DONE;

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] mem [DEPTH];

    weight_stream_reader #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .START     (START),
        .BRAM_EN   (BRAM_EN),
        .BRAM_WE   (BRAM_WE),
        .BRAM_ADDR (BRAM_ADDR),
        .BRAM_DI   (BRAM_DI),
        .BRAM_DO   (BRAM_DO),
        .W_DATA    (W_DATA),
        .W_INDEX   (W_INDEX),
        .W_VALID   (W_VALID),
        .W_LAST    (W_LAST),
        .W_READY   (W_READY),
        .BUSY      (BUSY),
        .DONE      (DONE)
    );

    always #5 CLK = ~CLK;

    // Negedge-clocked read port of the weight BRAM.
    always @(negedge CLK) begin
        if (BRAM_EN === 1'b1) begin
            if (int'(BRAM_ADDR) < DEPTH) begin
                BRAM_DO <= mem[BRAM_ADDR];
            end else begin
                BRAM_DO <= 16'hDEAD;
            end
        end
    end

    // One sweep with a given consumer mode: 0 = always ready, 1 = stall 6 cycles at index 3, 2 = random.
    // Cycle c counts from the edge that sampled START; with full rate the beats occupy c = 1..DEPTH,
    // the last beat leaves on the edge ending cycle DEPTH, so DONE is seen in c = DEPTH+1 and BUSY
    // is high from c = 0 through c = DEPTH.
    task automatic drive_sweep(input string name, input int mode, input bit skip_start,
                               input bit noise_start, input bit chain_next);
        int c, exp_idx, issued, accepted, stall_left;
        bit finished, prev_stall;
        logic [DATA_W-1:0] prev_data, exp_data;
        logic [ADDR_W-1:0] prev_index;
        c = 0; exp_idx = 0; issued = 0; accepted = 0; stall_left = 6;
        finished = 1'b0; prev_stall = 1'b0; prev_data = '0; prev_index = '0;
        if (!skip_start) begin
            START = 1'b1;
            @(posedge CLK); #1;
            START = 1'b0;
        end
        while (!finished && c < 400) begin
            if (c == 0) begin
                total++;
                if (BRAM_EN !== 1'b1 || BRAM_ADDR !== '0) begin
                    bad++;
                    $display("[TB] FAIL %s/first_issue: got en=%b addr=%0d want en=1 addr=0", name, BRAM_EN, BRAM_ADDR);
                end
            end
            if (BRAM_EN === 1'b1) begin
                issued++;
                total++;
                if (int'(BRAM_ADDR) != issued - 1) begin
                    bad++;
                    $display("[TB] FAIL %s/addr_order: got %0d want %0d", name, BRAM_ADDR, issued - 1);
                end
            end
            total++;
            if (BRAM_WE !== 1'b0 || BRAM_DI !== '0) begin
                bad++;
                $display("[TB] FAIL %s/bram_write: got we=%b di=%0h want we=0 di=0", name, BRAM_WE, BRAM_DI);
            end
            total++;
            if (issued - accepted > 2) begin
                bad++;
                $display("[TB] FAIL %s/outstanding: got %0d want <=2", name, issued - accepted);
            end
            if (prev_stall) begin
                total++;
                if (W_VALID !== 1'b1 || W_DATA !== prev_data || W_INDEX !== prev_index) begin
                    bad++;
                    $display("[TB] FAIL %s/stall_hold: got v=%b idx=%0d data=%0h want v=1 idx=%0d data=%0h",
                             name, W_VALID, W_INDEX, W_DATA, prev_index, prev_data);
                end
            end
            if (W_VALID === 1'b1) begin
                exp_data = DATA_W'(32'h0100 + exp_idx);
                total++;
                if (W_INDEX !== ADDR_W'(exp_idx) || W_DATA !== exp_data) begin
                    bad++;
                    $display("[TB] FAIL %s/beat: got idx=%0d data=%0h want idx=%0d data=%0h",
                             name, W_INDEX, W_DATA, exp_idx, exp_data);
                end
                total++;
                if (W_LAST !== (exp_idx == DEPTH - 1)) begin
                    bad++;
                    $display("[TB] FAIL %s/last: got %b want %b at idx %0d", name, W_LAST, (exp_idx == DEPTH - 1), exp_idx);
                end
                total++;
                if (BUSY !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL %s/busy_beat: got %b want 1", name, BUSY);
                end
            end
            if (mode == 0) begin
                total++;
                if (W_VALID !== (c >= 1 && c <= DEPTH)) begin
                    bad++;
                    $display("[TB] FAIL %s/rate_valid: got %b want %b at cycle %0d", name, W_VALID, (c >= 1 && c <= DEPTH), c);
                end
                total++;
                if (BUSY !== (c <= DEPTH)) begin
                    bad++;
                    $display("[TB] FAIL %s/busy_window: got %b want %b at cycle %0d", name, BUSY, (c <= DEPTH), c);
                end
                total++;
                if (DONE !== (c == DEPTH + 1)) begin
                    bad++;
                    $display("[TB] FAIL %s/done_time: got %b want %b at cycle %0d", name, DONE, (c == DEPTH + 1), c);
                end
            end
            if (DONE === 1'b1) begin
                finished = 1'b1;
                total++;
                if (accepted != DEPTH || issued != DEPTH || BUSY !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL %s/done_state: got acc=%0d iss=%0d busy=%b want acc=%0d iss=%0d busy=0",
                             name, accepted, issued, BUSY, DEPTH, DEPTH);
                end
            end
            case (mode)
                1: begin
                    W_READY = !(W_VALID === 1'b1 && W_INDEX == ADDR_W'(3) && stall_left > 0);
                    if (!W_READY) stall_left--;
                end
                2:       W_READY = 1'($urandom_range(0, 1));
                default: W_READY = 1'b1;
            endcase
            START      = (noise_start && (c == 5 || c == DEPTH - 1)) || (finished && chain_next);
            prev_stall = (W_VALID === 1'b1) && !W_READY;
            prev_data  = W_DATA;
            prev_index = W_INDEX;
            if (W_VALID === 1'b1 && W_READY) begin
                accepted++;
                exp_idx++;
            end
            @(posedge CLK); #1;
            START = 1'b0;
            c++;
        end
        total++;
        if (!finished) begin
            bad++;
            $display("[TB] FAIL %s/timeout: got no DONE after %0d cycles want DONE", name, c);
        end
        total++;
        if (DONE !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s/done_pulse: got %b want 0 in cycle after DONE", name, DONE);
        end
        if (!chain_next) begin
            total++;
            if (BUSY !== 1'b0 || BRAM_EN !== 1'b0 || W_VALID !== 1'b0) begin
                bad++;
                $display("[TB] FAIL %s/after_done: got busy=%b en=%b v=%b want 0 0 0", name, BUSY, BRAM_EN, W_VALID);
            end
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b1; START = 1'b0; W_READY = 1'b0;
        #2 RST_N = 1'b0;
        #2;
        total++;
        if ({BRAM_EN, BRAM_WE, BRAM_ADDR, BRAM_DI, W_DATA, W_INDEX, W_VALID, W_LAST, BUSY, DONE} !== '0) begin
            bad++;
            $display("[TB] FAIL reset/outputs: got en=%b we=%b addr=%0d v=%b busy=%b done=%b want all 0",
                     BRAM_EN, BRAM_WE, BRAM_ADDR, W_VALID, BUSY, DONE);
        end
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            total++;
            if (BRAM_EN !== 1'b0 || BRAM_WE !== 1'b0 || BUSY !== 1'b0 || W_VALID !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reset/idle: got en=%b we=%b busy=%b v=%b want 0 0 0 0", BRAM_EN, BRAM_WE, BUSY, W_VALID);
            end
        end
    endtask

    task automatic test_full_rate();
        drive_sweep("full_rate", 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        drive_sweep("backpressure", 1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random_ready();
        for (int s = 0; s < 3; s++) begin
            drive_sweep($sformatf("random%0d", s), 2, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        drive_sweep("start_noise", 0, 1'b0, 1'b1, 1'b1);
        drive_sweep("chained", 0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_stream();
        bit found;
        found = 1'b0;
        W_READY = 1'b1;
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (W_VALID === 1'b1 && W_INDEX == ADDR_W'(10)) begin
                found = 1'b1;
            end else begin
                @(posedge CLK); #1;
            end
        end
        total++;
        if (!found) begin
            bad++;
            $display("[TB] FAIL midreset/reach_idx10: got idx=%0d want 10", W_INDEX);
        end
        RST_N = 1'b0;
        #1;
        total++;
        if ({BRAM_EN, BRAM_ADDR, W_DATA, W_INDEX, W_VALID, W_LAST, BUSY, DONE} !== '0) begin
            bad++;
            $display("[TB] FAIL midreset/clear: got en=%b addr=%0d v=%b idx=%0d busy=%b want all 0",
                     BRAM_EN, BRAM_ADDR, W_VALID, W_INDEX, BUSY);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK); #1;
        total++;
        if (BRAM_EN !== 1'b0 || BUSY !== 1'b0 || W_VALID !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midreset/idle: got en=%b busy=%b v=%b want 0 0 0", BRAM_EN, BUSY, W_VALID);
        end
        drive_sweep("after_reset", 0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = DATA_W'(32'h0100 + i);
        end
        test_reset();
        @(posedge CLK); #1;
        test_full_rate();
        test_backpressure();
        test_random_ready();
        test_back_to_back();
        test_reset_mid_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
